// File: rtl/if_id_skid_pkg.sv
// Shared front-end definitions for the IF/ID stage: reset level, fetch bus
// widths, default skid depth and bubble instruction, occupancy width helper.
package if_id_skid_pkg;

    localparam logic RSTENABLE = 1'b1;

    localparam int unsigned INSTADDRBUS = 32;
    localparam int unsigned INSTDATABUS = 32;

    // IF may run ahead of a stalled ID by this many instructions.
    localparam int unsigned IFID_DEPTH = 2;

    // MIPS nop (sll $0,$0,0) presented to decode when the stage is empty.
    localparam logic [INSTDATABUS-1:0] NOP_INST = 32'h0000_0000;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle.
//   master : fetch/decode side (drives if_*, flush, id_ready)
//   slave  : the IF/ID stage (drives if_ready, id_*, count)
interface if_id_skid_if
    import if_id_skid_pkg::*;
#(
    parameter int unsigned PC_W   = INSTADDRBUS,
    parameter int unsigned INST_W = INSTDATABUS,
    parameter int unsigned DEPTH  = IFID_DEPTH
);

    logic                     if_valid;
    logic                     if_ready;
    logic [PC_W-1:0]          if_pc;
    logic [INST_W-1:0]        if_inst;
    logic                     flush;
    logic                     id_valid;
    logic                     id_ready;
    logic [PC_W-1:0]          id_pc;
    logic [INST_W-1:0]        id_inst;
    logic [occ_w(DEPTH)-1:0]  count;

    modport master (
        output if_valid, if_pc, if_inst, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count
    );

endinterface

// File: rtl/if_id_skid_stage_fifo.sv
// Generic pipeline-stage FIFO (circular buffer) shared by the IF/ID, ID/EX
// and EX/MEM stages. Every output is a flop, so there is no combinational
// path from rd_ready back to wr_ready.
//   clk, rst      : clock, synchronous active-high reset (also clears storage)
//   flush         : empty the FIFO on the next edge; beats push and pop
//   wr_valid/ready: write handshake, wr_ready low whenever full
//   wr_data       : payload written on push
//   rd_valid/ready: read handshake, rd_valid high whenever non-empty
//   rd_data       : head entry (meaningful only while rd_valid)
//   count         : occupancy 0..DEPTH
module if_id_skid_stage_fifo
    import if_id_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [occ_w(DEPTH)-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = occ_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             push;
    logic             pop;
    logic             head_from_wr;

    // Handshakes, next occupancy and the next head value.
    always_comb begin
        push         = wr_valid & wr_ready;
        pop          = rd_valid & rd_ready;
        rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
        count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
        // The incoming entry becomes the head when nothing else will be left.
        head_from_wr = push && ((count == '0) || (pop && (count == CNT_W'(1))));
        head_nxt     = rd_data;
        if (head_from_wr) begin
            head_nxt = wr_data;
        end else if (pop) begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Pointers, occupancy, status flags and the registered head copy.
    always_ff @(posedge clk) begin
        if (rst == RSTENABLE) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            wr_ready <= (count_nxt != FULL);
            rd_valid <= (count_nxt != '0);
            rd_data  <= head_nxt;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a DEPTH-entry skid buffer: IF keeps issuing
// while ID stalls, flush discards everything buffered, and every output is
// decoded from registers only.
//   clk, rst          : clock, synchronous active-high reset
//   bus.if_valid/ready: fetch handshake, if_ready low only when full
//   bus.if_pc/if_inst : fetched PC and instruction
//   bus.flush         : drop all buffered instructions (redirect)
//   bus.id_valid/ready: decode handshake on the head entry
//   bus.id_pc/id_inst : head entry, 0 / BUBBLE_INST while empty
//   bus.count         : occupancy 0..DEPTH
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int unsigned       PC_W        = INSTADDRBUS,
    parameter int unsigned       INST_W      = INSTDATABUS,
    parameter int unsigned       DEPTH       = IFID_DEPTH,
    parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(NOP_INST)
)(
    input logic          clk,
    input logic          rst,
    if_id_skid_if.slave  bus
);

    localparam int unsigned WIDTH = PC_W + INST_W;

    logic [WIDTH-1:0] head;
    logic             head_valid;

    if_id_skid_stage_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .wr_valid (bus.if_valid),
        .wr_ready (bus.if_ready),
        .wr_data  ({bus.if_pc, bus.if_inst}),
        .rd_valid (head_valid),
        .rd_ready (bus.id_ready),
        .rd_data  (head),
        .count    (bus.count)
    );

    // Empty stage shows a bubble so decode never acts on stale storage.
    assign bus.id_valid = head_valid;
    assign bus.id_pc    = head_valid ? head[WIDTH-1 -: PC_W] : '0;
    assign bus.id_inst  = head_valid ? head[INST_W-1:0]      : BUBBLE_INST;

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    localparam logic [31:0] BUB4 = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference contents of each stage, head first.
    logic [63:0] q2 [$];
    logic [63:0] q4 [$];

    always #5 clk = ~clk;

    if_id_skid_if #(.PC_W(32), .INST_W(32), .DEPTH(2)) b2 ();
    if_id_skid_if #(.PC_W(32), .INST_W(32), .DEPTH(4)) b4 ();

    if_id_skid #(.PC_W(32), .INST_W(32), .DEPTH(2), .BUBBLE_INST(32'h0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    if_id_skid #(.PC_W(32), .INST_W(32), .DEPTH(4), .BUBBLE_INST(BUB4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    // One clock edge: sample applied inputs, advance both reference queues, settle.
    task automatic tick();
        logic r, v2, y2, f2, v4, y4, f4;
        logic [63:0] e2, e4;
        bit acc, pop;
        r  = rst;
        v2 = b2.if_valid; y2 = b2.id_ready; f2 = b2.flush; e2 = {b2.if_pc, b2.if_inst};
        v4 = b4.if_valid; y4 = b4.id_ready; f4 = b4.flush; e4 = {b4.if_pc, b4.if_inst};
        @(posedge clk);
        if (r || f2) begin
            q2.delete();
        end else begin
            acc = v2 && (q2.size() < 2);
            pop = y2 && (q2.size() != 0);
            if (pop) void'(q2.pop_front());
            if (acc) q2.push_back(e2);
        end
        if (r || f4) begin
            q4.delete();
        end else begin
            acc = v4 && (q4.size() < 4);
            pop = y4 && (q4.size() != 0);
            if (pop) void'(q4.pop_front());
            if (acc) q4.push_back(e4);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b2.if_valid = 1'b1; b2.if_pc = 32'h40; b2.if_inst = 32'h1234; b2.id_ready = 1'b0; b2.flush = 1'b0;
        b4.if_valid = 1'b1; b4.if_pc = 32'h80; b4.if_inst = 32'h5678; b4.id_ready = 1'b0; b4.flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        b2.if_valid = 1'b0;
        b4.if_valid = 1'b0;
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", b2.id_valid); end
        n_checks++; if (b2.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", b2.id_pc); end
        n_checks++; if (b2.id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst: got %h want 0", b2.id_inst); end
        n_checks++; if (b2.count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", b2.count); end
        n_checks++; if (b2.if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b want 1", b2.if_ready); end
        n_checks++; if (b4.id_inst !== BUB4) begin n_fail++; $display("FAIL reset_bubble4: got %h want %h", b4.id_inst, BUB4); end
        n_checks++; if (b4.count !== 3'd0) begin n_fail++; $display("FAIL reset_count4: got %0d want 0", b4.count); end
    endtask

    task automatic test_streaming();
        logic [31:0] pc, inst;
        b2.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc   = 32'(4 * i);
            inst = 32'h2401_0001 + 32'(i);
            b2.if_valid = 1'b1; b2.if_pc = pc; b2.if_inst = inst;
            n_checks++; if (b2.if_ready !== 1'b1) begin n_fail++; $display("FAIL stream_if_ready %0d: got %b want 1", i, b2.if_ready); end
            tick();
            n_checks++; if (b2.id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid %0d: got %b want 1", i, b2.id_valid); end
            n_checks++; if (b2.id_pc !== pc) begin n_fail++; $display("FAIL stream_pc %0d: got %h want %h", i, b2.id_pc, pc); end
            n_checks++; if (b2.id_inst !== inst) begin n_fail++; $display("FAIL stream_inst %0d: got %h want %h", i, b2.id_inst, inst); end
            n_checks++; if (b2.count !== 2'd1) begin n_fail++; $display("FAIL stream_count %0d: got %0d want 1", i, b2.count); end
        end
        b2.if_valid = 1'b0;
        tick();
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b want 0", b2.id_valid); end
        n_checks++; if (b2.count !== 2'd0) begin n_fail++; $display("FAIL stream_drain_count: got %0d want 0", b2.count); end
    endtask

    task automatic test_stall_fill();
        b2.id_ready = 1'b0;
        b2.if_valid = 1'b1; b2.if_pc = 32'h100; b2.if_inst = 32'hA0;
        tick();
        b2.if_pc = 32'h104; b2.if_inst = 32'hA1;
        tick();
        n_checks++; if (b2.count !== 2'd2) begin n_fail++; $display("FAIL fill_count: got %0d want 2", b2.count); end
        n_checks++; if (b2.if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_if_ready: got %b want 0", b2.if_ready); end
        // IF holds 0x108 while the stage is full.
        b2.if_pc = 32'h108; b2.if_inst = 32'hA2;
        tick();
        n_checks++; if (b2.count !== 2'd2) begin n_fail++; $display("FAIL hold_count: got %0d want 2", b2.count); end
        n_checks++; if (b2.id_pc !== 32'h100) begin n_fail++; $display("FAIL hold_pc: got %h want 100", b2.id_pc); end
        n_checks++; if (b2.id_inst !== 32'hA0) begin n_fail++; $display("FAIL hold_inst: got %h want a0", b2.id_inst); end
        // Pop while full: the held push must still be refused this edge.
        b2.id_ready = 1'b1;
        tick();
        n_checks++; if (b2.id_pc !== 32'h104) begin n_fail++; $display("FAIL drain1_pc: got %h want 104", b2.id_pc); end
        n_checks++; if (b2.count !== 2'd1) begin n_fail++; $display("FAIL drain1_count: got %0d want 1", b2.count); end
        n_checks++; if (b2.if_ready !== 1'b1) begin n_fail++; $display("FAIL drain1_if_ready: got %b want 1", b2.if_ready); end
        tick();
        n_checks++; if (b2.id_pc !== 32'h108) begin n_fail++; $display("FAIL drain2_pc: got %h want 108", b2.id_pc); end
        n_checks++; if (b2.id_inst !== 32'hA2) begin n_fail++; $display("FAIL drain2_inst: got %h want a2", b2.id_inst); end
        n_checks++; if (b2.count !== 2'd1) begin n_fail++; $display("FAIL drain2_count: got %0d want 1", b2.count); end
        b2.if_valid = 1'b0;
        tick();
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL drain3_valid: got %b want 0", b2.id_valid); end
    endtask

    task automatic test_flush();
        b2.id_ready = 1'b0;
        b2.if_valid = 1'b1; b2.if_pc = 32'h180; b2.if_inst = 32'hB0;
        tick();
        b2.if_pc = 32'h184; b2.if_inst = 32'hB1;
        tick();
        n_checks++; if (b2.count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", b2.count); end
        b2.flush = 1'b1; b2.id_ready = 1'b1; b2.if_pc = 32'h200; b2.if_inst = 32'hB2;
        tick();
        b2.flush = 1'b0;
        n_checks++; if (b2.count !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", b2.count); end
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", b2.id_valid); end
        n_checks++; if (b2.id_inst !== 32'h0) begin n_fail++; $display("FAIL flush_inst: got %h want 0", b2.id_inst); end
        n_checks++; if (b2.id_pc !== 32'h0) begin n_fail++; $display("FAIL flush_pc: got %h want 0", b2.id_pc); end
        n_checks++; if (b2.if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_if_ready: got %b want 1", b2.if_ready); end
        b2.if_valid = 1'b0;
        tick();
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_deliver: got %b want 0", b2.id_valid); end
        // Flush with room available: the accepted push is still dropped.
        b2.id_ready = 1'b0; b2.if_valid = 1'b1; b2.if_pc = 32'h220; b2.if_inst = 32'hB3;
        tick();
        b2.flush = 1'b1; b2.if_pc = 32'h240; b2.if_inst = 32'hB4;
        tick();
        b2.flush = 1'b0; b2.if_valid = 1'b0;
        n_checks++; if (b2.count !== 2'd0) begin n_fail++; $display("FAIL flush_push_count: got %0d want 0", b2.count); end
        n_checks++; if (b2.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_valid: got %b want 0", b2.id_valid); end
    endtask

    task automatic test_push_pop();
        b2.id_ready = 1'b0; b2.if_valid = 1'b1; b2.if_pc = 32'h300; b2.if_inst = 32'hC0;
        tick();
        n_checks++; if (b2.id_pc !== 32'h300) begin n_fail++; $display("FAIL pp_first_pc: got %h want 300", b2.id_pc); end
        b2.id_ready = 1'b1; b2.if_pc = 32'h304; b2.if_inst = 32'hC1;
        tick();
        n_checks++; if (b2.count !== 2'd1) begin n_fail++; $display("FAIL pp_count: got %0d want 1", b2.count); end
        n_checks++; if (b2.id_pc !== 32'h304) begin n_fail++; $display("FAIL pp_pc: got %h want 304", b2.id_pc); end
        n_checks++; if (b2.id_inst !== 32'hC1) begin n_fail++; $display("FAIL pp_inst: got %h want c1", b2.id_inst); end
        b2.if_valid = 1'b0;
        tick();
        n_checks++; if (b2.count !== 2'd0) begin n_fail++; $display("FAIL pp_drain_count: got %0d want 0", b2.count); end
    endtask

    task automatic test_random();
        logic        ev, er;
        logic [31:0] epc, einst;
        logic [1:0]  ecnt;
        for (int c = 0; c < 300; c++) begin
            b2.if_valid = ($urandom_range(9) < 7);
            b2.if_pc    = $urandom;
            b2.if_inst  = $urandom;
            b2.id_ready = 1'($urandom_range(1));
            b2.flush    = ($urandom_range(15) == 0);
            tick();
            ev    = (q2.size() != 0);
            epc   = ev ? q2[0][63:32] : 32'h0;
            einst = ev ? q2[0][31:0]  : 32'h0;
            ecnt  = 2'(q2.size());
            er    = (q2.size() != 2);
            n_checks++; if (b2.id_valid !== ev) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, b2.id_valid, ev); end
            n_checks++; if (b2.id_pc !== epc) begin n_fail++; $display("FAIL rand_pc c%0d: got %h want %h", c, b2.id_pc, epc); end
            n_checks++; if (b2.id_inst !== einst) begin n_fail++; $display("FAIL rand_inst c%0d: got %h want %h", c, b2.id_inst, einst); end
            n_checks++; if (b2.count !== ecnt) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, b2.count, ecnt); end
            n_checks++; if (b2.if_ready !== er) begin n_fail++; $display("FAIL rand_if_ready c%0d: got %b want %b", c, b2.if_ready, er); end
        end
        b2.if_valid = 1'b0; b2.flush = 1'b0;
    endtask

    task automatic test_wrap();
        logic [63:0] sent [10];
        logic [63:0] got [$];
        logic        ev, er, acc;
        logic [31:0] epc, einst;
        logic [2:0]  ecnt;
        int          k;
        int          cyc;
        for (int i = 0; i < 10; i++) sent[i] = {32'h400 + 32'(4 * i), 32'($urandom)};
        k = 0;
        cyc = 0;
        while ((got.size() < 10) && (cyc < 200)) begin
            b4.if_valid = (k < 10);
            b4.if_pc    = (k < 10) ? sent[k][63:32] : 32'h0;
            b4.if_inst  = (k < 10) ? sent[k][31:0]  : 32'h0;
            b4.id_ready = ($urandom_range(2) != 0);
            acc = b4.if_valid && b4.if_ready;
            if (b4.id_valid && b4.id_ready) got.push_back({b4.id_pc, b4.id_inst});
            tick();
            if (acc) k++;
            ev    = (q4.size() != 0);
            epc   = ev ? q4[0][63:32] : 32'h0;
            einst = ev ? q4[0][31:0]  : BUB4;
            ecnt  = 3'(q4.size());
            er    = (q4.size() != 4);
            n_checks++; if (b4.id_valid !== ev) begin n_fail++; $display("FAIL wrap_valid c%0d: got %b want %b", cyc, b4.id_valid, ev); end
            n_checks++; if (b4.id_pc !== epc) begin n_fail++; $display("FAIL wrap_pc c%0d: got %h want %h", cyc, b4.id_pc, epc); end
            n_checks++; if (b4.id_inst !== einst) begin n_fail++; $display("FAIL wrap_inst c%0d: got %h want %h", cyc, b4.id_inst, einst); end
            n_checks++; if (b4.count !== ecnt) begin n_fail++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, b4.count, ecnt); end
            n_checks++; if (b4.if_ready !== er) begin n_fail++; $display("FAIL wrap_if_ready c%0d: got %b want %b", cyc, b4.if_ready, er); end
            cyc++;
        end
        b4.if_valid = 1'b0; b4.id_ready = 1'b0;
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_delivered: got %0d want 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL wrap_order %0d: got %h want %h", i, got[i], sent[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_push_pop();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised IF/ID pipeline stage with a valid/ready handshake, stall absorption, flush, and a small skid FIFO. It sits between instruction fetch and decode. It replaces the plain always-load IF/ID register. IF may keep issuing for up to DEPTH cycles while ID is stalled, and no combinational path runs from ID back-pressure to IF.

## Interface
- PC_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- DEPTH, 2, skid entries; power of two, ≥2.
- BUBBLE_INST, 0, instruction presented on id_inst when empty (0 = MIPS nop).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF offers an instruction this cycle.
- if_ready  out  1  stage can accept; function of registered occupancy only.
- if_pc  in  PC_W  fetched PC.
- if_inst  in  INST_W  fetched instruction.
- flush  in  1  discard all buffered instructions (branch/exception redirect).
- id_valid  out  1  head entry valid.
- id_ready  in  1  ID consumes head this cycle (0 = ID stall).
- id_pc  out  PC_W  head PC; 0 when !id_valid.
- id_inst  out  INST_W  head instruction; BUBBLE_INST when !id_valid.
- count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH.

## Operation
- Circular buffer: mem[DEPTH], wr_ptr, rd_ptr (each $clog2(DEPTH) bits, wrap modulo DEPTH), count.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = (count != DEPTH); full stage refuses a push even when a pop occurs in the same cycle.
- id_valid = (count != 0); id_pc/id_inst = mem[rd_ptr], masked to 0/BUBBLE_INST when empty.
- On push: mem[wr_ptr] ← {if_pc, if_inst}, wr_ptr+1.
- On pop: rd_ptr+1.
- count += push − pop; push and pop in one cycle leave count unchanged.
- flush: next edge sets count=0 and rd_ptr=wr_ptr=0. Flush beats a same-cycle push and pop, and the push is dropped. if_ready stays as computed, so IF sees its offer as accepted; the redirect is IF's job.
- rst: identical to flush, and also clears every mem entry to 0. Reset mid-stream drops all entries.
- push with if_valid=0, or pop with id_valid=0, is a no-op. Inputs while !if_ready are ignored, and IF must hold them.

## Timing
- Latency: an instruction pushed at edge N appears on id_* with id_valid=1 from edge N through N+1, the same one-cycle latency as the classic IF/ID register.
- Steady flow (if_valid=1, id_ready=1): one instruction per cycle, count stays 1.
- After reset/flush: id_valid=0, id_pc=0, id_inst=BUBBLE_INST, count=0, if_ready=1.
- if_ready, id_valid, id_pc, id_inst and count depend only on registers. There are no input→output combinational paths.
- id_* hold stable while id_valid=1 and id_ready=0.

## Structure
- Shared defines file (existing): RSTENABLE, ZEROWORD, INSTADDRBUS/INSTDATABUS widths. DEPTH and BUBBLE_INST defaults are added there as IFID_DEPTH and NOP_INST.
- Sub-module stage_fifo (WIDTH, DEPTH): pointers, count, storage, flush. if_id_skid instantiates it with WIDTH=PC_W+INST_W and adds the empty masking. stage_fifo is reused for later ID/EX and EX/MEM successors.

## Test plan
- Reset: rst=1 for 2 cycles with if_valid=1 → id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1 after release.
- Streaming: push PCs 0x0,0x4,0x8 with insts 0x24010001.. and id_ready=1 → each appears on id_* exactly 1 cycle after acceptance, in order, and count stays ≤1.
- Stall/fill (DEPTH=2): id_ready=0 and push 0x100,0x104 → count=2, if_ready=0, and 0x108 is held by IF. Then id_ready=1 → 0x100, 0x104, 0x108 delivered in order with no loss or duplication.
- Flush: count=2, flush=1 with if_valid=1 (pc 0x200) → next cycle count=0, id_valid=0, id_inst=BUBBLE_INST, and 0x200 is never delivered.
- Simultaneous push/pop at count=1: count stays 1, and id_* advances to the new PC.
- Wrap: DEPTH=4, 10 pushes with random id_ready → output order matches input order across pointer wrap.
